// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round sequencer: LFSR mole patterns, hit capture, score handoff
// Define MOLE_SPEEDUP_EN to shrink the ACTIVE window every four rounds.
module mole_round_ctrl #(
   parameter int NUM_MOLES    = 18,
   parameter int ROUND_CYCLES = 50_000_000,
   parameter int GAP_CYCLES   = 12_500_000,
   parameter int NUM_ROUNDS   = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] sw,
   output logic [NUM_MOLES-1:0] led_moles,
   output logic [NUM_MOLES-1:0] hit_reg,
   output logic                 round_done,
   output logic [7:0]           round_num,
   output logic                 game_over
);

   localparam int WCW = $clog2(ROUND_CYCLES);
   localparam int GCW = $clog2(GAP_CYCLES + 1);
   localparam logic [31:0] LFSR_SEED = 32'hACE10001;
   localparam logic [31:0] LFSR_MASK = 32'h80200003;

   typedef enum logic [2:0] {IDLE, SPAWN, ACTIVE, SCORE, GAP, DONE} state_t;
   state_t state;

   logic [31:0]          lfsr;
   logic [NUM_MOLES-1:0] sync1, sync2, prev, rise;
   logic [NUM_MOLES-1:0] pattern, hits, hits_next;
   logic [NUM_MOLES-1:0] lfsr_and, spawn_pat;
   logic [4:0]           one_idx;
   logic [WCW-1:0]       win_cnt, window_last;
   logic [GCW-1:0]       gap_cnt;

   // prev tracks every cycle, so a switch already high when a round opens never counts
   assign rise      = sync2 & ~prev;
   assign hits_next = hits | (rise & pattern);

   // An empty AND of the two LFSR slices falls back to a single lit mole
   assign lfsr_and  = lfsr[NUM_MOLES-1:0] & lfsr[31:32-NUM_MOLES];
   assign one_idx   = 5'(lfsr[4:0] % 5'(NUM_MOLES));
   assign spawn_pat = (lfsr_and != '0) ? lfsr_and
                                       : ({{(NUM_MOLES-1){1'b0}}, 1'b1} << one_idx);

`ifdef MOLE_SPEEDUP_EN
   localparam int WIN_FLOOR = ROUND_CYCLES / 4;
   localparam int WIN_STEP  = ROUND_CYCLES / 8;
   logic [31:0] shrink;

   // Saturate at the floor instead of letting the subtraction wrap
   always_comb begin
      shrink = 32'(round_num >> 2) * 32'(WIN_STEP);
      if (shrink >= 32'(ROUND_CYCLES - WIN_FLOOR))
         window_last = WCW'(WIN_FLOOR - 1);
      else
         window_last = WCW'(32'(ROUND_CYCLES) - shrink - 32'd1);
   end
`else
   assign window_last = WCW'(ROUND_CYCLES - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         sync1      <= '0;
         sync2      <= '0;
         prev       <= '0;
         pattern    <= '0;
         hits       <= '0;
         win_cnt    <= '0;
         gap_cnt    <= '0;
         led_moles  <= '0;
         hit_reg    <= '0;
         round_done <= 1'b0;
         round_num  <= '0;
         game_over  <= 1'b0;
      end else begin
         lfsr       <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
         sync1      <= sw;
         sync2      <= sync1;
         prev       <= sync2;
         round_done <= 1'b0;
         hit_reg    <= '0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= SPAWN;
                  round_num <= '0;
                  game_over <= 1'b0;
               end
            end
            SPAWN: begin
               pattern   <= spawn_pat;
               led_moles <= spawn_pat;
               hits      <= '0;
               win_cnt   <= '0;
               state     <= ACTIVE;
            end
            ACTIVE: begin
               hits    <= hits_next;
               win_cnt <= win_cnt + WCW'(1);
               if (hits_next == pattern || win_cnt == window_last) begin
                  state      <= SCORE;
                  hit_reg    <= hits_next;
                  round_done <= 1'b1;
                  round_num  <= round_num + 8'd1;
               end
            end
            SCORE: begin
               led_moles <= '0;
               gap_cnt   <= '0;
               if (round_num == 8'(NUM_ROUNDS)) begin
                  state     <= DONE;
                  game_over <= 1'b1;
               end else begin
                  state <= GAP;
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + GCW'(1);
               if (gap_cnt == GCW'(GAP_CYCLES - 1))
                  state <= SPAWN;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
